// File: rtl/dummy_accelerator_pkg.sv
// Shared types and default widths for the dummy accelerator issuer.
// Contents:
//   - DA_* localparams: the default widths. The packed types below are sized
//     from them, so they must match the issuer's parameter values.
//   - acc_tag_t:   tag carried with each request and result, as {rd, id}.
//   - rob_entry_t: one reorder-buffer slot, as {busy, done, rd, data}.
package dummy_accelerator_pkg;

   localparam int unsigned DA_WIDTH     = 32;
   localparam int unsigned DA_IMM_WIDTH = 11;
   localparam int unsigned DA_RD_WIDTH  = 5;
   localparam int unsigned DA_ID_WIDTH  = 2;

   typedef struct packed {
      logic [DA_RD_WIDTH-1:0] rd;
      logic [DA_ID_WIDTH-1:0] id;
   } acc_tag_t;

   typedef struct packed {
      logic                   busy;
      logic                   done;
      logic [DA_RD_WIDTH-1:0] rd;
      logic [DA_WIDTH-1:0]    data;
   } rob_entry_t;

endpackage

// File: rtl/dummy_accelerator_rob.sv
// Reorder buffer for the dummy accelerator issuer. Slots are allocated in
// issue order. Results may fill slots in any order. Slots retire in order
// from the head.
// Ports:
//   clk_i, rst_i, flush_i        clock, synchronous reset, flush (both clear all state)
//   alloc_i, alloc_rd_i          allocate the slot at alloc_id_o for register rd
//   alloc_id_o                   id of the next slot to allocate
//   wr_i, wr_id_i, wr_rd_i,      write a result into slot wr_id_i. The write
//   wr_data_i                    takes effect only when wr_legal_o is high.
//   wr_legal_o                   the addressed slot is busy, not done, and its rd matches
//   head_valid_o, head_rd_o,     oldest slot holds a finished result
//   head_data_o, pop_i           pop_i retires the head slot
//   count_o                      number of allocated slots
module dummy_accelerator_rob
   import dummy_accelerator_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   alloc_i,
   input  logic [DA_RD_WIDTH-1:0] alloc_rd_i,
   output logic [DA_ID_WIDTH-1:0] alloc_id_o,
   input  logic                   wr_i,
   input  logic [DA_ID_WIDTH-1:0] wr_id_i,
   input  logic [DA_RD_WIDTH-1:0] wr_rd_i,
   input  logic [DA_WIDTH-1:0]    wr_data_i,
   output logic                   wr_legal_o,
   output logic                   head_valid_o,
   output logic [DA_RD_WIDTH-1:0] head_rd_o,
   output logic [DA_WIDTH-1:0]    head_data_o,
   input  logic                   pop_i,
   output logic [DA_ID_WIDTH:0]   count_o
);

   localparam int unsigned DEPTH = 2 ** DA_ID_WIDTH;

   rob_entry_t             slot_q [DEPTH];
   rob_entry_t             slot_d [DEPTH];
   logic [DA_ID_WIDTH-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [DA_ID_WIDTH-1:0] retire_ptr_q, retire_ptr_d;
   logic [DA_ID_WIDTH:0]   count_q, count_d;

   assign alloc_id_o   = alloc_ptr_q;
   assign count_o      = count_q;
   assign wr_legal_o   = slot_q[wr_id_i].busy && !slot_q[wr_id_i].done &&
                         (slot_q[wr_id_i].rd == wr_rd_i);
   assign head_valid_o = slot_q[retire_ptr_q].busy && slot_q[retire_ptr_q].done;
   assign head_rd_o    = slot_q[retire_ptr_q].rd;
   assign head_data_o  = slot_q[retire_ptr_q].data;

   // An allocation, a result and a retirement in the same cycle always touch
   // different slots. Allocation needs a free slot. A result needs a busy slot
   // that is not done. Retirement needs a done slot.
   always_comb begin
      slot_d       = slot_q;
      alloc_ptr_d  = alloc_ptr_q;
      retire_ptr_d = retire_ptr_q;
      count_d      = count_q;
      if (alloc_i) begin
         slot_d[alloc_ptr_q].busy = 1'b1;
         slot_d[alloc_ptr_q].done = 1'b0;
         slot_d[alloc_ptr_q].rd   = alloc_rd_i;
         alloc_ptr_d              = alloc_ptr_q + DA_ID_WIDTH'(1);
      end
      if (wr_i && wr_legal_o) begin
         slot_d[wr_id_i].done = 1'b1;
         slot_d[wr_id_i].data = wr_data_i;
      end
      if (pop_i) begin
         slot_d[retire_ptr_q].busy = 1'b0;
         slot_d[retire_ptr_q].done = 1'b0;
         retire_ptr_d              = retire_ptr_q + DA_ID_WIDTH'(1);
      end
      case ({alloc_i, pop_i})
         2'b10:   count_d = count_q + (DA_ID_WIDTH+1)'(1);
         2'b01:   count_d = count_q - (DA_ID_WIDTH+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
         alloc_ptr_q  <= '0;
         retire_ptr_q <= '0;
         count_q      <= '0;
      end else begin
         slot_q       <= slot_d;
         alloc_ptr_q  <= alloc_ptr_d;
         retire_ptr_q <= retire_ptr_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: rtl/dummy_accelerator_issuer.sv
// Initiator side of the dummy accelerator. It tags core requests with
// {rd, id} and issues them through a one-entry output register. It collects
// results, which may return out of order, in a reorder buffer, and writes
// them back in issue order.
// Ports:
//   clk_i, rst_i, flush_i            clock, synchronous active-high reset, flush
//   req_valid_i/req_ready_o,         core request: rs1, imm, rd
//   req_rs1_i/req_imm_i/req_rd_i
//   acc_valid_o/acc_ready_i,         issue channel to the accelerator (registered)
//   acc_rs1_o/acc_imm_o/acc_tag_o
//   res_valid_i/res_ready_o,         result channel (always ready)
//   res_data_i/res_tag_i
//   wb_valid_o/wb_ready_i,           in-order register-file writeback
//   wb_rd_o/wb_data_o
//   outstanding_o, idle_o            allocated ROB slots, and high when none are allocated
//   proto_err_o                      sticky illegal-result flag, cleared only by reset
module dummy_accelerator_issuer
   import dummy_accelerator_pkg::*;
#(
   parameter int unsigned WIDTH     = DA_WIDTH,
   parameter int unsigned IMM_WIDTH = DA_IMM_WIDTH,
   parameter int unsigned RD_WIDTH  = DA_RD_WIDTH,
   parameter int unsigned ID_WIDTH  = DA_ID_WIDTH
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [WIDTH-1:0]             req_rs1_i,
   input  logic [IMM_WIDTH-1:0]         req_imm_i,
   input  logic [RD_WIDTH-1:0]          req_rd_i,
   output logic                         acc_valid_o,
   input  logic                         acc_ready_i,
   output logic [WIDTH-1:0]             acc_rs1_o,
   output logic [IMM_WIDTH-1:0]         acc_imm_o,
   output logic [RD_WIDTH+ID_WIDTH-1:0] acc_tag_o,
   input  logic                         res_valid_i,
   output logic                         res_ready_o,
   input  logic [WIDTH-1:0]             res_data_i,
   input  logic [RD_WIDTH+ID_WIDTH-1:0] res_tag_i,
   output logic                         wb_valid_o,
   input  logic                         wb_ready_i,
   output logic [RD_WIDTH-1:0]          wb_rd_o,
   output logic [WIDTH-1:0]             wb_data_o,
   output logic [ID_WIDTH:0]            outstanding_o,
   output logic                         idle_o,
   output logic                         proto_err_o
);

   localparam logic [ID_WIDTH:0] DEPTH_C = (ID_WIDTH+1)'(2 ** ID_WIDTH);

   logic                 acc_valid_q, acc_valid_d;
   logic [WIDTH-1:0]     acc_rs1_q, acc_rs1_d;
   logic [IMM_WIDTH-1:0] acc_imm_q, acc_imm_d;
   acc_tag_t             acc_tag_q, acc_tag_d;
   logic                 proto_err_q, proto_err_d;

   acc_tag_t             res_tag;
   logic [ID_WIDTH-1:0]  alloc_id;
   logic [ID_WIDTH:0]    count;
   logic                 req_fire, res_wr, wr_legal, wb_pop;

   assign res_tag     = res_tag_i;
   assign req_ready_o = !rst_i && (count < DEPTH_C) && (!acc_valid_q || acc_ready_i);
   assign req_fire    = req_valid_i && req_ready_o;
   // Results arriving in a flush cycle are dropped. They neither fill a slot
   // nor count as a protocol error.
   assign res_wr      = res_valid_i && !flush_i;
   assign wb_pop      = wb_valid_o && wb_ready_i;

   assign res_ready_o   = 1'b1;
   assign acc_valid_o   = acc_valid_q;
   assign acc_rs1_o     = acc_rs1_q;
   assign acc_imm_o     = acc_imm_q;
   assign acc_tag_o     = acc_tag_q;
   assign outstanding_o = count;
   assign idle_o        = (count == '0);
   assign proto_err_o   = proto_err_q;

   always_comb begin
      acc_valid_d = acc_valid_q;
      acc_rs1_d   = acc_rs1_q;
      acc_imm_d   = acc_imm_q;
      acc_tag_d   = acc_tag_q;
      proto_err_d = proto_err_q;
      if (req_fire) begin
         acc_valid_d  = 1'b1;
         acc_rs1_d    = req_rs1_i;
         acc_imm_d    = req_imm_i;
         acc_tag_d.rd = req_rd_i;
         acc_tag_d.id = alloc_id;
      end else if (acc_ready_i) begin
         acc_valid_d = 1'b0;
      end
      if (res_wr && !wr_legal) proto_err_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_valid_q <= 1'b0;
         acc_rs1_q   <= '0;
         acc_imm_q   <= '0;
         acc_tag_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= proto_err_d;
         if (flush_i) begin
            acc_valid_q <= 1'b0;
            acc_rs1_q   <= '0;
            acc_imm_q   <= '0;
            acc_tag_q   <= '0;
         end else begin
            acc_valid_q <= acc_valid_d;
            acc_rs1_q   <= acc_rs1_d;
            acc_imm_q   <= acc_imm_d;
            acc_tag_q   <= acc_tag_d;
         end
      end
   end

   dummy_accelerator_rob u_rob (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .alloc_i      (req_fire),
      .alloc_rd_i   (req_rd_i),
      .alloc_id_o   (alloc_id),
      .wr_i         (res_wr),
      .wr_id_i      (res_tag.id),
      .wr_rd_i      (res_tag.rd),
      .wr_data_i    (res_data_i),
      .wr_legal_o   (wr_legal),
      .head_valid_o (wb_valid_o),
      .head_rd_o    (wb_rd_o),
      .head_data_o  (wb_data_o),
      .pop_i        (wb_pop),
      .count_o      (count)
   );

endmodule

// File: tb/tb_dummy_accelerator_issuer.sv
module tb_dummy_accelerator_issuer;

   logic        clk = 1'b0;
   logic        rst_i, flush_i;
   logic        req_valid_i, req_ready_o;
   logic [31:0] req_rs1_i;
   logic [10:0] req_imm_i;
   logic [4:0]  req_rd_i;
   logic        acc_valid_o, acc_ready_i;
   logic [31:0] acc_rs1_o;
   logic [10:0] acc_imm_o;
   logic [6:0]  acc_tag_o;
   logic        res_valid_i, res_ready_o;
   logic [31:0] res_data_i;
   logic [6:0]  res_tag_i;
   logic        wb_valid_o, wb_ready_i;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic [2:0]  outstanding_o;
   logic        idle_o, proto_err_o;

   always #5 clk = ~clk;

   dummy_accelerator_issuer dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_rs1_i     (req_rs1_i),
      .req_imm_i     (req_imm_i),
      .req_rd_i      (req_rd_i),
      .acc_valid_o   (acc_valid_o),
      .acc_ready_i   (acc_ready_i),
      .acc_rs1_o     (acc_rs1_o),
      .acc_imm_o     (acc_imm_o),
      .acc_tag_o     (acc_tag_o),
      .res_valid_i   (res_valid_i),
      .res_ready_o   (res_ready_o),
      .res_data_i    (res_data_i),
      .res_tag_i     (res_tag_i),
      .wb_valid_o    (wb_valid_o),
      .wb_ready_i    (wb_ready_i),
      .wb_rd_o       (wb_rd_o),
      .wb_data_o     (wb_data_o),
      .outstanding_o (outstanding_o),
      .idle_o        (idle_o),
      .proto_err_o   (proto_err_o)
   );

   typedef struct { logic [31:0] rs1; logic [10:0] imm; logic [6:0] tag; } iss_t;
   typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

   iss_t exp_iss[$];
   wb_t  exp_wb[$];
   iss_t mon_iss;
   wb_t  mon_wb;
   int   checks   = 0;
   int   failures = 0;
   bit   stim_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] rs1, input logic [10:0] imm,
                      input logic [4:0] rd, input logic [1:0] id);
      req_valid_i = 1'b1;
      req_rs1_i   = rs1;
      req_imm_i   = imm;
      req_rd_i    = rd;
      exp_iss.push_back('{rs1, imm, {rd, id}});
   endtask

   task automatic res(input logic [4:0] rd, input logic [1:0] id, input logic [31:0] d);
      res_valid_i = 1'b1;
      res_tag_i   = {rd, id};
      res_data_i  = d;
   endtask

   task automatic exp_wbk(input logic [4:0] rd, input logic [31:0] d);
      exp_wb.push_back('{rd, d});
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 1'b0;
      req_valid_i = 1'b0; req_rs1_i = '0; req_imm_i = '0; req_rd_i = '0;
      acc_ready_i = 1'b1; res_valid_i = 1'b0; res_data_i = '0; res_tag_i = '0;
      wb_ready_i = 1'b1;
      fork
         // monitor: pops expectations on every issue / writeback handshake
         begin
            while (!stim_done) begin
               @(negedge clk);
               if (!rst_i) begin
                  if (acc_valid_o && acc_ready_i) begin
                     if (exp_iss.size() == 0) chk("iss_unexpected", 64'(acc_tag_o), 64'h7f00);
                     else begin
                        mon_iss = exp_iss.pop_front();
                        chk("iss_rs1", 64'(acc_rs1_o), 64'(mon_iss.rs1));
                        chk("iss_imm", 64'(acc_imm_o), 64'(mon_iss.imm));
                        chk("iss_tag", 64'(acc_tag_o), 64'(mon_iss.tag));
                     end
                  end
                  if (wb_valid_o && wb_ready_i) begin
                     if (exp_wb.size() == 0) chk("wb_unexpected", 64'(wb_rd_o), 64'h7f00);
                     else begin
                        mon_wb = exp_wb.pop_front();
                        chk("wb_rd", 64'(wb_rd_o), 64'(mon_wb.rd));
                        chk("wb_data", 64'(wb_data_o), 64'(mon_wb.data));
                     end
                  end
               end
            end
         end
         // stimulus
         begin
            // reset state
            step(); step();
            chk("rst_req_ready", 64'(req_ready_o), 0);
            chk("rst_acc_valid", 64'(acc_valid_o), 0);
            chk("rst_wb_valid", 64'(wb_valid_o), 0);
            chk("rst_outstanding", 64'(outstanding_o), 0);
            chk("rst_idle", 64'(idle_o), 1);
            chk("rst_err", 64'(proto_err_o), 0);
            chk("rst_res_ready", 64'(res_ready_o), 1);
            rst_i = 1'b0;
            #1 chk("post_rst_req_ready", 64'(req_ready_o), 1);

            // single request, zero-latency result
            req(32'h10, 11'h5, 5'd3, 2'd0);
            step();
            req_valid_i = 1'b0;
            chk("t1_acc_valid", 64'(acc_valid_o), 1);
            chk("t1_acc_tag", 64'(acc_tag_o), 64'h0c);
            chk("t1_outstanding", 64'(outstanding_o), 1);
            res(5'd3, 2'd0, 32'h15);
            exp_wbk(5'd3, 32'h15);
            step();
            res_valid_i = 1'b0;
            chk("t1_wb_valid", 64'(wb_valid_o), 1);
            chk("t1_wb_rd", 64'(wb_rd_o), 3);
            chk("t1_wb_data", 64'(wb_data_o), 64'h15);
            step();
            chk("t1_idle", 64'(idle_o), 1);

            // realign pointers, then fill all four slots
            flush_i = 1'b1; step(); flush_i = 1'b0;
            for (int i = 0; i < 4; i++) begin
               req(32'h100 + 32'(i), 11'(i), 5'(i + 1), 2'(i));
               step();
            end
            req_valid_i = 1'b0;
            chk("full_req_ready", 64'(req_ready_o), 0);
            chk("full_outstanding", 64'(outstanding_o), 4);

            // out-of-order results 2,0,3,1 -> in-order writeback
            exp_wbk(5'd1, 32'h200); exp_wbk(5'd2, 32'h201);
            exp_wbk(5'd3, 32'h202); exp_wbk(5'd4, 32'h203);
            res(5'd3, 2'd2, 32'h202);
            step();
            chk("ooo_wait_id0", 64'(wb_valid_o), 0);
            res(5'd1, 2'd0, 32'h200);
            step();
            res_valid_i = 1'b0;
            chk("ooo_id0_wb", 64'(wb_valid_o), 1);
            chk("ooo_full_before", 64'(outstanding_o), 4);
            step();
            chk("ooo_freed_outstanding", 64'(outstanding_o), 3);
            chk("ooo_freed_ready", 64'(req_ready_o), 1);
            req(32'h333, 11'h33, 5'd7, 2'd0);
            res(5'd4, 2'd3, 32'h203);
            step();
            req_valid_i = 1'b0;
            chk("wrap_tag", 64'(acc_tag_o), 64'h1c);
            chk("wrap_outstanding", 64'(outstanding_o), 4);
            chk("ooo_wait_id1", 64'(wb_valid_o), 0);
            res(5'd2, 2'd1, 32'h201);
            step();
            res_valid_i = 1'b0;
            chk("ooo_id1_wb", 64'(wb_valid_o), 1);
            exp_wbk(5'd7, 32'h777);
            step(); step(); step();
            chk("drain_outstanding", 64'(outstanding_o), 1);
            chk("drain_wb_valid", 64'(wb_valid_o), 0);
            res(5'd7, 2'd0, 32'h777);
            step();
            res_valid_i = 1'b0;
            chk("wrap_wb_valid", 64'(wb_valid_o), 1);
            step();
            chk("wrap_idle", 64'(idle_o), 1);

            // issue backpressure: outputs stable, competing request refused
            acc_ready_i = 1'b0;
            req(32'hABCD, 11'h7F, 5'd5, 2'd1);
            step();
            req_valid_i = 1'b1; req_rs1_i = 32'hDEAD; req_imm_i = 11'h11; req_rd_i = 5'd9;
            for (int i = 0; i < 3; i++) begin
               chk("bp_acc_valid", 64'(acc_valid_o), 1);
               chk("bp_acc_rs1", 64'(acc_rs1_o), 64'hABCD);
               chk("bp_acc_imm", 64'(acc_imm_o), 64'h7F);
               chk("bp_acc_tag", 64'(acc_tag_o), 64'h15);
               chk("bp_req_ready", 64'(req_ready_o), 0);
               step();
            end
            req_valid_i = 1'b0;
            acc_ready_i = 1'b1;
            step();
            chk("bp_released", 64'(acc_valid_o), 0);
            chk("bp_outstanding", 64'(outstanding_o), 1);

            // rd mismatch on an allocated slot
            res(5'd6, 2'd1, 32'h999);
            step();
            res_valid_i = 1'b0;
            chk("rdmis_err", 64'(proto_err_o), 1);
            chk("rdmis_wb_valid", 64'(wb_valid_o), 0);
            chk("rdmis_outstanding", 64'(outstanding_o), 1);
            rst_i = 1'b1; step(); rst_i = 1'b0;
            chk("rst2_err", 64'(proto_err_o), 0);
            chk("rst2_outstanding", 64'(outstanding_o), 0);

            // flush with 3 outstanding and an (otherwise illegal) result
            for (int i = 0; i < 3; i++) begin
               req(32'h1000 + 32'(i), 11'h40 + 11'(i), 5'(10 + i), 2'(i));
               step();
            end
            req_valid_i = 1'b0;
            flush_i = 1'b1;
            res(5'd12, 2'd3, 32'hBAD);
            step();
            flush_i = 1'b0; res_valid_i = 1'b0;
            chk("flush_outstanding", 64'(outstanding_o), 0);
            chk("flush_idle", 64'(idle_o), 1);
            chk("flush_acc_valid", 64'(acc_valid_o), 0);
            chk("flush_err_kept0", 64'(proto_err_o), 0);
            chk("flush_wb_valid", 64'(wb_valid_o), 0);

            // result for an unallocated id, sticky through flush
            res(5'd9, 2'd3, 32'h123);
            step();
            res_valid_i = 1'b0;
            chk("unalloc_err", 64'(proto_err_o), 1);
            chk("unalloc_wb_valid", 64'(wb_valid_o), 0);
            flush_i = 1'b1; step(); flush_i = 1'b0;
            chk("flush_err_kept1", 64'(proto_err_o), 1);
            chk("flush2_idle", 64'(idle_o), 1);

            // after flush the next request starts again at id 0
            req(32'h2, 11'h1, 5'd2, 2'd0);
            step();
            req_valid_i = 1'b0;
            chk("post_flush_tag", 64'(acc_tag_o), 64'h08);
            res(5'd2, 2'd0, 32'h3);
            exp_wbk(5'd2, 32'h3);
            step();
            res_valid_i = 1'b0;
            chk("post_flush_wb", 64'(wb_valid_o), 1);
            step(); step();
            chk("end_idle", 64'(idle_o), 1);
            chk("end_iss_queue", 64'(exp_iss.size()), 0);
            chk("end_wb_queue", 64'(exp_wb.size()), 0);
            stim_done = 1'b1;
         end
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
